scoreboard_regfile: RTL
=======================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width; 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NREAD, default 2, number of independent read ports (1..8).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port wen  input  1  writeback enable.
REQ-007 SHALL have port waddr  input  ADDR_WIDTH  writeback address.
REQ-008 SHALL have port wdata  input  DATA_WIDTH  writeback data.
REQ-009 SHALL have port iss_en  input  1  issue; marks iss_addr pending.
REQ-010 SHALL have port iss_addr  input  ADDR_WIDTH  destination being issued.
REQ-011 SHALL have port raddr  input  NREAD*ADDR_WIDTH  read addresses; port i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port rdata  output  NREAD*DATA_WIDTH  read data; same packing as raddr.
REQ-013 SHALL have port rbusy  output  NREAD  bit i set: register at port i is pending.
REQ-014 SHALL have port pend_cnt  output  ADDR_WIDTH  registered count of pending entries.

Function
REQ-015 Entry 0 SHALL always read as zero, never become pending; wen and iss_en targeting address 0 SHALL be ignored.
REQ-016 Reads SHALL be combinational (zero latency); all NREAD ports independent, any address mix, including identical addresses.
REQ-017 wen=1 with waddr!=0 SHALL write wdata into entry waddr at the clock edge, whether or not it is pending.
REQ-018 wen=1 with waddr!=0 SHALL clear pending[waddr] at the clock edge.
REQ-019 iss_en=1 with iss_addr!=0 SHALL set pending[iss_addr] at the clock edge.
REQ-020 iss_en and wen on the same nonzero address in one cycle SHALL leave the entry pending (set wins) and the data written.
REQ-021 iss_en on an already-pending address SHALL keep it pending and SHALL NOT change pend_cnt.
REQ-022 pend_cnt SHALL equal the number of set pending bits after each edge: +1 on a new set, -1 on a clear of a set bit, unchanged when both occur on distinct addresses; never wraps (maximum 2**ADDR_WIDTH-1).
REQ-023 rbusy[i] SHALL be pending[raddr_i] from the state register, subject to REQ-026.

Reset
REQ-024 rst=1 at a clock edge SHALL clear all data entries to zero, all pending bits, and pend_cnt to 0; rst SHALL override wen and iss_en in that cycle.
REQ-025 After reset, rdata SHALL be all zeros and rbusy all zeros until the first write or issue; rst asserted mid-operation SHALL discard all pending state.

Configuration
REQ-026 Macro SCOREBOARD_REGFILE_BYPASS_EN defined: a read port whose nonzero raddr matches waddr while wen=1 SHALL return wdata and rbusy=0 in that same cycle, except rbusy=1 if iss_en targets the same address in that cycle. Not defined: rdata and rbusy SHALL reflect stored state only; the write becomes visible the cycle after the edge.

Verification
REQ-027 Reset, then read all addresses on all ports -> rdata=0, rbusy=0, pend_cnt=0.
REQ-028 iss_en addr 5; next cycle wen addr 5 data 0xDEADBEEF, raddr0=5 -> rbusy[0]=1 before the edge, 0 after; rdata0=0xDEADBEEF after the edge; pend_cnt 1 then 0.
REQ-029 Same cycle iss_en addr 7 and wen addr 7 data 0x12 -> after the edge: entry 7 reads 0x12, rbusy=1, pend_cnt=1.
REQ-030 wen addr 0 data 0xFFFFFFFF and iss_en addr 0 -> reads of address 0 return 0, rbusy=0, pend_cnt unchanged.
REQ-031 With BYPASS_EN: wen addr 3 data 0xA5, raddr0=raddr1=3 same cycle -> both rdata=0xA5 combinationally. Without BYPASS_EN: old value that cycle, 0xA5 next cycle.
REQ-032 Issue addresses 1..31 on consecutive cycles, then assert rst mid-sequence -> pend_cnt tracks 1..k, then 0 with all rbusy clear after the reset edge.

Source files
------------

// File: rtl/scoreboard_regfile.sv
// ---------------------------------------------------------------------------
// scoreboard_regfile
//   Register file with a per-entry "pending" scoreboard bit. Issue marks a
//   destination pending; writeback stores data and clears the pending bit.
//   Entry 0 is hard-wired to zero and can never become pending.
//   NREAD independent combinational read ports, each reporting data and busy.
//   pend_cnt is a registered count of pending entries.
//
//   Optional feature: define SCOREBOARD_REGFILE_BYPASS_EN to forward the
//   writeback value (and its cleared busy state) to a matching read port in the
//   same cycle. Without it, reads reflect stored state only.
//
//   Handshake: none. wen and iss_en are single-cycle qualifiers, sampled on
//   every rising clk edge while rst is low. rst has priority over both.
// ---------------------------------------------------------------------------
module scoreboard_regfile #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NREAD      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wen,
   input  logic [ADDR_WIDTH-1:0]       waddr,
   input  logic [DATA_WIDTH-1:0]       wdata,
   input  logic                        iss_en,
   input  logic [ADDR_WIDTH-1:0]       iss_addr,
   input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
   output logic [NREAD*DATA_WIDTH-1:0] rdata,
   output logic [NREAD-1:0]            rbusy,
   output logic [ADDR_WIDTH-1:0]       pend_cnt
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]      r_pend;
   logic [ADDR_WIDTH-1:0] r_cnt;

   // Address 0 is never written or marked pending.
   logic w_wr_valid;
   logic w_iss_valid;
   // Count moves up only on a genuinely new pending bit, down only when a set
   // bit is really cleared (a same-address issue keeps it set).
   logic w_inc;
   logic w_dec;

   assign w_wr_valid  = wen && (waddr != '0);
   assign w_iss_valid = iss_en && (iss_addr != '0);
   assign w_inc       = w_iss_valid && !r_pend[iss_addr];
   assign w_dec       = w_wr_valid && r_pend[waddr] &&
                        !(w_iss_valid && (iss_addr == waddr));

   // Storage and scoreboard update; issue is applied after writeback so set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_pend <= '0;
      end else begin
         if (w_wr_valid) begin
            r_mem[waddr]  <= wdata;
            r_pend[waddr] <= 1'b0;
         end
         if (w_iss_valid) begin
            r_pend[iss_addr] <= 1'b1;
         end
      end
   end

   // Pending-entry counter; cannot exceed DEPTH-1 since entry 0 never counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         case ({w_inc, w_dec})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign pend_cnt = r_cnt;

   // Independent combinational read ports.
   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic                  w_hit;

      assign w_ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef SCOREBOARD_REGFILE_BYPASS_EN
      // Forward a same-cycle writeback to this port.
      assign w_hit = w_wr_valid && (w_ra == waddr);
`else
      assign w_hit = 1'b0;
`endif

      assign rdata[g*DATA_WIDTH +: DATA_WIDTH] =
         (w_ra == '0) ? '0 : (w_hit ? wdata : r_mem[w_ra]);
      // A forwarded write reads as not busy unless re-issued in the same cycle.
      assign rbusy[g] =
         w_hit ? (w_iss_valid && (iss_addr == w_ra)) : r_pend[w_ra];
   end

endmodule
